// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD timing engine.
package lcd_pkg;

    // Transfer phases, in the order a write walks through them.
    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StWait
    } lcd_state_e;

    // Field positions inside the 32-bit LCD register word.
    localparam int unsigned LCD_ON_BIT   = 31;
    localparam int unsigned LCD_RS_BIT   = 9;
    localparam int unsigned LCD_DATA_LSB = 0;

    // LSU address of the LCD register.
    localparam logic [31:0] LCD_ADDR = 32'h0000_04A0;

    // Commands that need the long execution wait (clear display / return home).
    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
    localparam logic [7:0] LCD_CMD_HOME_ALT = 8'h03;

    // Wide enough for the 1.52 ms wait at 50 MHz.
    localparam int unsigned CNT_W = 17;

    // True for instruction writes that the panel executes slowly.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME ||
                       data == LCD_CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// Write-only HD44780 timing engine: latches an LCD word and sequences
// setup, enable pulse, hold and execution wait on registered pins.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP     = 4,
    parameter int unsigned T_EN        = 23,
    parameter int unsigned T_HOLD      = 1,
    parameter int unsigned T_EXEC      = 1850,
    parameter int unsigned T_EXEC_LONG = 76000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] lcd_word_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        drop_o,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o
);

    lcd_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] wait_len_q;

    logic       word_rs;
    logic [7:0] word_data;
    logic       unused_word_bits;

    assign word_rs   = lcd_word_i[LCD_RS_BIT];
    assign word_data = lcd_word_i[LCD_DATA_LSB +: 8];

    // Fields of the register word the panel does not use.
    assign unused_word_bits = ^{lcd_word_i[30:10], lcd_word_i[8]};

    // Panel is only ever written.
    assign lcd_rw_o = 1'b0;

    // Transfer FSM with one shared down-counter; every pin output is registered here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            wait_len_q <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            drop_o     <= 1'b0;
            lcd_on_o   <= 1'b0;
            lcd_en_o   <= 1'b0;
            lcd_rs_o   <= 1'b0;
            lcd_data_o <= '0;
        end else begin
            done_o <= 1'b0;
            // A request outside IDLE is rejected; the latched word is left untouched.
            drop_o <= req_i && (state_q != StIdle);

            case (state_q)
                StIdle: begin
                    if (req_i) begin
                        lcd_on_o   <= lcd_word_i[LCD_ON_BIT];
                        lcd_rs_o   <= word_rs;
                        lcd_data_o <= word_data;
                        wait_len_q <= is_long_cmd(word_rs, word_data) ?
                                      CNT_W'(T_EXEC_LONG) : CNT_W'(T_EXEC);
                        cnt_q      <= CNT_W'(T_SETUP - 1);
                        busy_o     <= 1'b1;
                        state_q    <= StSetup;
                    end
                end

                StSetup: begin
                    if (cnt_q == '0) begin
                        cnt_q    <= CNT_W'(T_EN - 1);
                        lcd_en_o <= 1'b1;
                        state_q  <= StPulse;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                StPulse: begin
                    if (cnt_q == '0) begin
                        cnt_q    <= CNT_W'(T_HOLD - 1);
                        lcd_en_o <= 1'b0;
                        state_q  <= StHold;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                StHold: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= wait_len_q - CNT_W'(1);
                        // A one-cycle wait is already its own last cycle.
                        done_o  <= (wait_len_q == CNT_W'(1));
                        state_q <= StWait;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                StWait: begin
                    if (cnt_q == '0) begin
                        busy_o  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q  <= cnt_q - CNT_W'(1);
                        // Flag the cycle in which the counter reaches zero.
                        done_o <= (cnt_q == CNT_W'(1));
                    end
                end

                default: begin
                    busy_o   <= 1'b0;
                    lcd_en_o <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters and a queue of
// expected transfers that is popped as each transfer is walked cycle by cycle.
module tb_lcd_ctrl;

    localparam int unsigned T_SETUP     = 2;
    localparam int unsigned T_EN        = 3;
    localparam int unsigned T_HOLD      = 1;
    localparam int unsigned T_EXEC      = 5;
    localparam int unsigned T_EXEC_LONG = 20;

    // Busy lengths: setup + enable + hold + wait.
    localparam int LEN_SHORT = 11;
    localparam int LEN_LONG  = 26;

    typedef struct {
        logic       on;
        logic       rs;
        logic [7:0] data;
        int         len;
    } txn_t;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] lcd_word;
    logic        busy, done, drop, lcd_on, lcd_en, lcd_rs, lcd_rw;
    logic [7:0]  lcd_data;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   en_pulses = 0;

    lcd_ctrl #(
        .T_SETUP     (T_SETUP),
        .T_EN        (T_EN),
        .T_HOLD      (T_HOLD),
        .T_EXEC      (T_EXEC),
        .T_EXEC_LONG (T_EXEC_LONG)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .lcd_word_i (lcd_word),
        .busy_o     (busy),
        .done_o     (done),
        .drop_o     (drop),
        .lcd_on_o   (lcd_on),
        .lcd_en_o   (lcd_en),
        .lcd_rs_o   (lcd_rs),
        .lcd_rw_o   (lcd_rw),
        .lcd_data_o (lcd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count enable pulses independently of the per-cycle checks.
    always @(posedge lcd_en) en_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".drop"}, 32'(drop), 32'd0);
        chk({tag, ".on"},   32'(lcd_on), 32'd0);
        chk({tag, ".en"},   32'(lcd_en), 32'd0);
        chk({tag, ".rs"},   32'(lcd_rs), 32'd0);
        chk({tag, ".rw"},   32'(lcd_rw), 32'd0);
        chk({tag, ".data"}, 32'(lcd_data), 32'd0);
    endtask

    // Strobe one request across edge k and record what the bench expects from it.
    task automatic drive_req(input logic [31:0] w, input logic on, input logic rs,
                             input logic [7:0] data, input int len);
        txn_t t;
        t.on = on;
        t.rs = rs;
        t.data = data;
        t.len = len;
        exp_q.push_back(t);
        req = 1'b1;
        lcd_word = w;
        step();
        req = 1'b0;
    endtask

    // Walk cycles k+1 .. k+len+1 of the oldest expected transfer.
    // drop_at > 0 injects a second request sampled at edge k+drop_at.
    task automatic check_txn(input string tag, input int drop_at, input logic [31:0] drop_w);
        txn_t t;
        int   en_lo, en_hi;
        t = exp_q.pop_front();
        en_lo = T_SETUP + 1;
        en_hi = T_SETUP + T_EN;
        for (int n = 1; n <= t.len + 1; n++) begin
            chk($sformatf("%s.busy@%0d", tag, n), 32'(busy), 32'(n <= t.len));
            chk($sformatf("%s.en@%0d", tag, n), 32'(lcd_en), 32'(n >= en_lo && n <= en_hi));
            chk($sformatf("%s.done@%0d", tag, n), 32'(done), 32'(n == t.len));
            chk($sformatf("%s.drop@%0d", tag, n), 32'(drop),
                32'(drop_at > 0 && n == drop_at + 1));
            chk($sformatf("%s.on@%0d", tag, n), 32'(lcd_on), 32'(t.on));
            chk($sformatf("%s.rs@%0d", tag, n), 32'(lcd_rs), 32'(t.rs));
            chk($sformatf("%s.data@%0d", tag, n), 32'(lcd_data), 32'(t.data));
            chk($sformatf("%s.rw@%0d", tag, n), 32'(lcd_rw), 32'd0);
            if (n == drop_at) begin
                req = 1'b1;
                lcd_word = drop_w;
            end
            if (n <= t.len) begin
                step();
                req = 1'b0;
            end
        end
    endtask

    initial begin
        txn_t discard;
        rst = 1'b1;
        req = 1'b0;
        lcd_word = '0;

        // Reset values, both while held and after release.
        repeat (3) step();
        chk_all_zero("rst_held");
        rst = 1'b0;
        step();
        chk_all_zero("rst_released");
        step();

        // Data write with an overlapping request at k+4 that must be dropped.
        drive_req(32'h8000_0241, 1'b1, 1'b1, 8'h41, LEN_SHORT);
        check_txn("data41", 4, 32'h8000_0242);
        chk("en_pulses_after_data41", 32'(en_pulses), 32'd1);

        // Issued in the first idle cycle: accepted with no bubble and no drop.
        drive_req(32'h0000_0055, 1'b0, 1'b0, 8'h55, LEN_SHORT);
        check_txn("b2b55", 0, '0);
        chk("en_pulses_after_b2b55", 32'(en_pulses), 32'd2);

        // Clear display takes the long wait.
        step();
        drive_req(32'h8000_0001, 1'b1, 1'b0, 8'h01, LEN_LONG);
        check_txn("clear", 0, '0);
        chk("en_pulses_after_clear", 32'(en_pulses), 32'd3);

        // Data 0x03 with RS=1 is a character, not a long command.
        step();
        drive_req(32'h8000_0203, 1'b1, 1'b1, 8'h03, LEN_SHORT);
        check_txn("rs1_03", 0, '0);

        // Reset while EN is high: EN and busy drop before the next edge, no done follows.
        step();
        drive_req(32'h8000_0248, 1'b1, 1'b1, 8'h48, LEN_SHORT);
        discard = exp_q.pop_front();
        step();
        step();
        chk("abort.en_before", 32'(lcd_en), 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("abort.in_reset");
        step();
        rst = 1'b0;
        for (int i = 0; i < LEN_SHORT; i++) begin
            chk($sformatf("abort.nodone@%0d", i), 32'(done), 32'd0);
            chk($sformatf("abort.idle@%0d", i), 32'(busy), 32'd0);
            step();
        end

        // Return home after the abort completes normally with the long wait.
        drive_req(32'h0000_0002, 1'b0, 1'b0, 8'h02, LEN_LONG);
        check_txn("home", 0, '0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
